layer_controller: RTL and testbench

LAYER_CONTROLLER -- requirements
Module: layer_controller

---
 rtl/layer_controller.sv | 105 ++++++++++
 tb/tb_layer_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_controller.sv
// Layer sequencer: starts all neurons together, gathers each result once,
// then presents the full layer downstream, with a WAIT-phase timeout.
module layer_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_NEURONS    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic                                    neuron_start,
    input  logic [NUM_NEURONS-1:0]                  neuron_done,
    input  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]  neuron_out,
    output logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]  layer_out,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    busy,
    output logic                                    error,
    input  logic                                    error_clear,
    output logic [$clog2(NUM_NEURONS+1)-1:0]        done_count
);

    localparam int CW = $clog2(NUM_NEURONS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_OUTPUT,
        S_ERROR
    } state_t;

    state_t                                  state_q;
    logic [NUM_NEURONS-1:0]                  flags_q;
    logic [CW-1:0]                           count_q;
    logic [TW-1:0]                           timer_q;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]  data_q;

    logic [NUM_NEURONS-1:0] hits;
    logic [CW-1:0]          hit_cnt;
    logic                   all_set;
    logic                   timer_last;

    // Only first pulses from not-yet-flagged neurons count toward completion
    always_comb begin
        hits    = neuron_done & ~flags_q;
        hit_cnt = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (hits[i]) hit_cnt = hit_cnt + CW'(1);
        end
        all_set    = &(flags_q | neuron_done);
        timer_last = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            flags_q <= '0;
            count_q <= '0;
            timer_q <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) state_q <= S_START;
                end
                S_START: begin
                    flags_q <= '0;
                    count_q <= '0;
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        if (hits[i]) data_q[i] <= neuron_out[i];
                    end
                    flags_q <= flags_q | neuron_done;
                    count_q <= count_q + hit_cnt;
                    timer_q <= timer_q + TW'(1);
                    // Completion takes priority over a coincident timeout
                    if (all_set)         state_q <= S_OUTPUT;
                    else if (timer_last) state_q <= S_ERROR;
                end
                S_OUTPUT: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                S_ERROR: begin
                    if (error_clear) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign neuron_start = (state_q == S_START);
    assign out_valid    = (state_q == S_OUTPUT);
    assign error        = (state_q == S_ERROR);
    assign layer_out    = data_q;
    assign done_count   = count_q;

endmodule

// File: tb/tb_layer_controller.sv
// Randomized bench for layer_controller: each pass is predicted from a
// per-neuron pulse schedule (first in-window pulse wins, 16-cycle window).
module tb_layer_controller;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;
    localparam int CW = $clog2(N + 1);

    localparam int ST_IDLE  = 0;
    localparam int ST_START = 1;
    localparam int ST_WAIT  = 2;
    localparam int ST_OUT   = 3;
    localparam int ST_ERR   = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic                error_clear = 1'b0;
    logic                in_ready, neuron_start, out_valid, busy, error;
    logic [N-1:0]        neuron_done = '0;
    logic [N-1:0][W-1:0] neuron_out = '0;
    logic [N-1:0][W-1:0] layer_out;
    logic [CW-1:0]       done_count;

    int checks = 0;
    int errors = 0;

    // Model state: layer contents left by earlier passes, plus the pass plan
    logic [W-1:0] prev_lo[N];
    int           pc0[N];
    int           pc1[N];
    logic [W-1:0] pv0[N];
    logic [W-1:0] pv1[N];

    always #5 clock = ~clock;

    layer_controller #(
        .DATA_WIDTH(W),
        .NUM_NEURONS(N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .neuron_start(neuron_start),
        .neuron_done(neuron_done),
        .neuron_out(neuron_out),
        .layer_out(layer_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .error(error),
        .error_clear(error_clear),
        .done_count(done_count)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_ctl(input int st);
        check("in_ready", 64'(in_ready), 64'(st == ST_IDLE));
        check("busy", 64'(busy), 64'(st != ST_IDLE));
        check("neuron_start", 64'(neuron_start), 64'(st == ST_START));
        check("out_valid", 64'(out_valid), 64'(st == ST_OUT));
        check("error", 64'(error), 64'(st == ST_ERR));
    endtask

    task automatic check_reset_vals();
        check_ctl(ST_IDLE);
        check("rst_done_count", 64'(done_count), 64'd0);
        for (int i = 0; i < N; i++) check("rst_layer_out", 64'(layer_out[i]), 64'd0);
    endtask

    // Called at a negedge while the DUT idles; cycle 0 is the transfer cycle
    task automatic run_pass(input int hold);
        int           eff[N];
        logic [W-1:0] ev[N];
        int           fin;
        int           last;
        int           st;
        int           nc;
        bit           all;
        for (int i = 0; i < N; i++) begin
            eff[i] = -1;
            ev[i]  = '0;
            if (pc0[i] >= 2 && pc0[i] <= TO + 1) begin
                eff[i] = pc0[i];
                ev[i]  = pv0[i];
            end
            if (pc1[i] >= 2 && pc1[i] <= TO + 1 && (eff[i] == -1 || pc1[i] < eff[i])) begin
                eff[i] = pc1[i];
                ev[i]  = pv1[i];
            end
        end
        all = 1'b1;
        fin = 0;
        for (int i = 0; i < N; i++) begin
            if (eff[i] == -1) all = 1'b0;
            else if (eff[i] > fin) fin = eff[i];
        end
        if (!all) fin = TO + 1;
        last = fin + 2 + hold;

        check_ctl(ST_IDLE);
        in_valid    = 1'b1;
        neuron_done = '0;
        out_ready   = 1'b0;
        error_clear = 1'b0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clock);
            if (c == 1)         st = ST_START;
            else if (c <= fin)  st = ST_WAIT;
            else if (c < last)  st = all ? ST_OUT : ST_ERR;
            else                st = ST_IDLE;
            check_ctl(st);
            if (c >= 2) begin
                nc = 0;
                for (int i = 0; i < N; i++) if (eff[i] != -1 && eff[i] < c) nc++;
                check("done_count", 64'(done_count), 64'(nc));
                for (int i = 0; i < N; i++) begin
                    check("layer_out", 64'(layer_out[i]),
                          64'((eff[i] != -1 && eff[i] < c) ? ev[i] : prev_lo[i]));
                end
            end
            if (c == last) begin
                in_valid    = 1'b0;
                neuron_done = '0;
                out_ready   = 1'b0;
                error_clear = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    neuron_done[i] = (pc0[i] == c) || (pc1[i] == c);
                    neuron_out[i]  = (pc0[i] == c) ? pv0[i] :
                                     (pc1[i] == c) ? pv1[i] : W'($urandom);
                end
                in_valid    = 1'($urandom % 2);
                error_clear = (c == last - 1) && !all;
                if (c == last - 1) out_ready = 1'b1;
                else if (st == ST_OUT) out_ready = 1'b0;
                else out_ready = 1'($urandom % 2);
            end
        end
        for (int i = 0; i < N; i++) if (eff[i] != -1) prev_lo[i] = ev[i];
    endtask

    task automatic reset_mid_wait();
        check_ctl(ST_IDLE);
        in_valid = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            in_valid = 1'b0;
            if (c == 6) check("pre_rst_count", 64'(done_count), 64'd2);
            neuron_done[0] = (c == 3);
            neuron_done[1] = (c == 4);
            neuron_out[0]  = 32'd55;
            neuron_out[1]  = 32'hFFFF_FF00;
        end
        #2 reset = 1'b1;
        #1 check_reset_vals();
        neuron_done = '0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < N; i++) prev_lo[i] = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check_reset_vals();
        end
    endtask

    task automatic set_plan(input int a0, a1, a2, a3,
                            input logic [W-1:0] v0, v1, v2, v3);
        pc0[0] = a0; pc0[1] = a1; pc0[2] = a2; pc0[3] = a3;
        pv0[0] = v0; pv0[1] = v1; pv0[2] = v2; pv0[3] = v3;
        for (int i = 0; i < N; i++) begin
            pc1[i] = -1;
            pv1[i] = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) prev_lo[i] = '0;
        #2 check_reset_vals();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals();

        // Nominal: dones at cycles 5..8
        set_plan(5, 6, 7, 8, 32'd10, 32'hFFFF_FFFD, 32'd7, 32'd0);
        run_pass(0);

        // All at once, then a duplicate on neuron 2
        set_plan(5, 5, 5, 5, 32'd1, 32'd2, 32'd3, 32'd4);
        pc1[2] = 6;
        pv1[2] = 32'd99;
        run_pass(0);

        // Back-pressure for 10 cycles, plus a START-cycle pulse
        set_plan(3, 4, 1, 9, 32'd11, 32'd22, 32'd33, 32'd44);
        pc1[2] = 6;
        pv1[2] = 32'd66;
        run_pass(10);

        // Timeout: neuron 3 silent
        set_plan(4, 7, 10, -1, 32'd5, 32'd6, 32'hFFFF_FFF8, 32'd9);
        run_pass(5);

        // Last done in the 16th WAIT cycle
        set_plan(2, 10, 12, TO + 1, 32'd100, 32'd200, 32'd300, 32'hFFFF_FE70);
        run_pass(1);

        // One cycle too late: times out with three captured
        set_plan(2, 3, 4, TO + 2, 32'd7, 32'd8, 32'd9, 32'd10);
        run_pass(2);

        reset_mid_wait();
        set_plan(5, 6, 7, 8, 32'd10, 32'hFFFF_FFFD, 32'd7, 32'd0);
        run_pass(0);

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                int r;
                r = int'($urandom % 10);
                pc0[i] = (r == 0) ? -1 : (r == 1) ? 1 : int'($urandom_range(2, TO + 1));
                pc1[i] = ($urandom % 3 == 0) ? int'($urandom_range(1, TO + 4)) : -1;
                pv0[i] = W'($urandom);
                pv1[i] = W'($urandom);
            end
            run_pass(int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
